mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit 4:1 output datapath among four requesters.
- Registers the grant, drives the 2-bit mux select and captures the granted input into a registered output with a valid flag.
- Bounds each tenure to MAX_HOLD cycles so no requester can starve the others.
- Sits between four producer blocks and a single downstream consumer of the shared 4-bit bus.

---
 rtl/mux_rr_arbiter_pkg.sv | 6 +
 rtl/mux_rr_arbiter_pick.sv | 20 ++
 rtl/mux_rr_arbiter.sv | 85 ++++++++
 tb/tb_mux_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared constants and FSM encoding for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// rr_priority_pick: first requester at or after ptr, searching upward with wrap
//   req   : request vector
//   ptr   : index with highest priority
//   found : any request present
//   idx   : winning index (ptr when none)
module rr_priority_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = |req;
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[ptr + IDX_W'(k)]) idx = ptr + IDX_W'(k);
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin 4:1 arbiter with bounded tenure and registered data output
//   clk, rst_n       : clock, async active-low reset
//   req              : level-sensitive requests
//   i0..i3           : requester data
//   gnt, sel         : registered one-hot grant and grantee index
//   out, out_valid   : registered granted sample and its valid flag
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  state_t             r_state, w_state_nx;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nx;
  logic [IDX_W-1:0]   r_sel, w_sel_nx, r_ptr, w_ptr_nx, w_idx;
  logic [HOLD_W-1:0]  r_hold, w_hold_nx;
  logic [WIDTH-1:0]   r_out, w_data;
  logic               r_valid, w_found, w_keep, w_fire;

  rr_priority_pick u_pick (.req(req), .ptr(r_ptr), .found(w_found), .idx(w_idx));

  // ptr is always grantee+1 while busy, so a release search naturally ranks the grantee last
  assign w_keep = (r_state == BUSY) && req[r_sel] && (r_hold < HOLD_W'(MAX_HOLD));
  assign w_fire = |(r_gnt & req);
  assign w_data = (r_sel == 2'd0) ? i0 : (r_sel == 2'd1) ? i1 : (r_sel == 2'd2) ? i2 : i3;

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx = r_gnt;
    w_sel_nx = r_sel;
    w_ptr_nx = r_ptr;
    w_hold_nx = r_hold;
    if (w_keep) begin
      w_hold_nx = r_hold + 1'b1;
    end else if (w_found) begin
      w_state_nx = BUSY;
      w_gnt_nx = N_REQ'(1) << w_idx;
      w_sel_nx = w_idx;
      w_ptr_nx = w_idx + 1'b1;
      w_hold_nx = HOLD_W'(1);
    end else begin
      w_state_nx = IDLE;
      w_gnt_nx = '0;
      w_hold_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_sel <= '0;
      r_ptr <= '0;
      r_hold <= '0;
      r_out <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt <= w_gnt_nx;
      r_sel <= w_sel_nx;
      r_ptr <= w_ptr_nx;
      r_hold <= w_hold_nx;
      if (w_fire) r_out <= w_data;
      r_valid <= w_fire;
    end
  end

  assign gnt = r_gnt;
  assign sel = r_sel;
  assign out = r_out;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench comparing MAX_HOLD=4 and MAX_HOLD=1 arbiters against a reference model
module tb_mux_rr_arbiter;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic [3:0] o;
    logic       v;
  } exp_t;

  logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] dat [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] gnt_o [2];
  logic [1:0] sel_o [2];
  logic [3:0] out_o [2];
  logic       val_o [2];

  exp_t [1:0] q[$];
  exp_t [1:0] em;
  int vectors = 0, miscompares = 0;

  int busy [2], cur [2], hc [2], p [2];
  int mh [2] = '{4, 1};
  logic [3:0] mout [2];

  initial forever #5 if (clk_en) clk = ~clk;

  mux_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4), .HOLD_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req), .i0(dat[0]), .i1(dat[1]), .i2(dat[2]), .i3(dat[3]),
    .gnt(gnt_o[0]), .sel(sel_o[0]), .out(out_o[0]), .out_valid(val_o[0]));

  mux_rr_arbiter #(.WIDTH(4), .MAX_HOLD(1), .HOLD_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .i0(dat[0]), .i1(dat[1]), .i2(dat[2]), .i3(dat[3]),
    .gnt(gnt_o[1]), .sel(sel_o[1]), .out(out_o[1]), .out_valid(val_o[1]));

  task automatic chk(input string name, input int d, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[mh=%0d] t=%0t: got %0h, expected %0h", name, mh[d], $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int j = 0; j < 4; j++)
      if (r[(from + j) % 4]) return (from + j) % 4;
    return -1;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; cur[d] = 0; hc[d] = 0; p[d] = 0; mout[d] = '0;
    end
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, gnt_o[d], 0);
      chk("rst_sel", d, sel_o[d], 0);
      chk("rst_out", d, out_o[d], 0);
      chk("rst_valid", d, val_o[d], 0);
    end
  endtask

  // Apply one cycle of requests and queue what each arbiter must show after the next edge
  task automatic step(input logic [3:0] r);
    exp_t [1:0] e;
    int k;
    logic v;
    req = r;
    for (int d = 0; d < 2; d++) begin
      v = (busy[d] != 0) && r[cur[d]];
      if (v) mout[d] = dat[cur[d]];
      if (busy[d] != 0 && r[cur[d]] && hc[d] < mh[d]) begin
        hc[d]++;
      end else begin
        k = pick(r, p[d]);
        if (k >= 0) begin
          busy[d] = 1; cur[d] = k; hc[d] = 1; p[d] = (k + 1) % 4;
        end else begin
          busy[d] = 0;
        end
      end
      e[d].g = busy[d] != 0 ? 4'(1 << cur[d]) : 4'h0;
      e[d].s = 2'(cur[d]);
      e[d].o = mout[d];
      e[d].v = v;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset();
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      em = q.pop_front();
      for (int d = 0; d < 2; d++) begin
        chk("gnt", d, gnt_o[d], em[d].g);
        chk("sel", d, sel_o[d], em[d].s);
        chk("out_valid", d, val_o[d], em[d].v);
        chk("out", d, out_o[d], em[d].o);
      end
    end
  end

  initial begin
    logic [3:0] r;
    mreset();
    #20 chk_reset();
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(4'b0000);
    dat = '{4'h0, 4'h0, 4'hA, 4'h0};
    for (int i = 0; i < 10; i++) step(4'b0100);
    step(4'b0000);
    do_reset();
    dat = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 18; i++) step(4'b1111);
    do_reset();
    dat = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 3; i++) step(4'b1010);
    for (int i = 0; i < 3; i++) step(4'b1000);
    step(4'b1111);
    step(4'b1111);
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1010);
    dat = '{4'h9, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 8; i++) step(4'b1001);
    step(4'b0000);
    r = 4'h0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) dat[k] = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step(r);
    end
    step(4'b0000);
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
